// File: rtl/sa_pkg.sv
// Shared types and length helpers for the systolic-array sequencer.
package sa_pkg;

    // Sequencer phases for one job.
    typedef enum logic [2:0] {
        SA_IDLE    = 3'd0,
        SA_LOAD_W  = 3'd1,
        SA_COMPUTE = 3'd2,
        SA_DRAIN   = 3'd3,
        SA_DONE    = 3'd4
    } sa_ctrl_state_e;

    // Default array geometry; modules recompute lengths from their own parameters.
    localparam int SA_ROWS   = 4;
    localparam int SA_COLS   = 4;
    localparam int SA_RD_LAT = 1;

    // Weight preload: ROWS read cycles plus the buffer read latency.
    function automatic int sa_load_len(input int rows, input int rd_lat);
        return rows + rd_lat;
    endfunction

    // Drain: time for the last read to reach the bottom row of the last column.
    function automatic int sa_drain_len(input int rows, input int cols, input int rd_lat);
        return rd_lat + rows + cols - 1;
    endfunction

    localparam int SA_LOAD_LEN  = sa_load_len(SA_ROWS, SA_RD_LAT);
    localparam int SA_DRAIN_LEN = sa_drain_len(SA_ROWS, SA_COLS, SA_RD_LAT);

endpackage

// File: rtl/sa_vld_pipe.sv
// Delay line turning the activation read strobe into per-column output-valid strobes.
module sa_vld_pipe
    import sa_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_strobe,
    output logic [COLS-1:0] o_col_vld
);

    // Longest tap is RD_LAT+ROWS+COLS-1 cycles, i.e. the drain length.
    localparam int DEPTH = sa_drain_len(ROWS, COLS, RD_LAT);

    logic [DEPTH-1:0] r_sr;

    // Shift the read strobe; bit i holds the strobe delayed by i+1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else begin
            r_sr <= {r_sr[DEPTH-2:0], i_strobe};
        end
    end

    // Column c sees its psum RD_LAT+ROWS+c cycles after the read.
    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_tap
            assign o_col_vld[gi] = r_sr[RD_LAT + ROWS + gi - 1];
        end
    endgenerate

endmodule

// File: rtl/sa_ctrl.sv
// Job sequencer for the weight-stationary systolic array: preload, compute, drain, done.
module sa_ctrl
    import sa_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_skip_wload,
    input  logic [CNT_W-1:0]  i_num_act,
    input  logic [ADDR_W-1:0] i_wgt_base,
    input  logic [ADDR_W-1:0] i_act_base,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mode,
    output logic              o_wgt_rd_en,
    output logic [ADDR_W-1:0] o_wgt_rd_addr,
    output logic              o_act_rd_en,
    output logic [ADDR_W-1:0] o_act_rd_addr,
    output logic [COLS-1:0]   o_col_vld
);

    localparam int LOAD_LEN  = sa_load_len(ROWS, RD_LAT);
    localparam int DRAIN_LEN = sa_drain_len(ROWS, COLS, RD_LAT);
    localparam int CW        = $clog2(RD_LAT + ROWS + COLS);

    localparam logic [CW-1:0]     LOAD_LAST  = CW'(LOAD_LEN - 1);
    localparam logic [CW-1:0]     DRAIN_LAST = CW'(DRAIN_LEN - 1);
    localparam logic [CW-1:0]     ROWS_C     = CW'(ROWS);
    localparam logic [ADDR_W-1:0] WGT_TOP    = ADDR_W'(ROWS - 1);

    sa_ctrl_state_e    r_state, w_state_next;
    logic [CW-1:0]     r_cnt, w_cnt_next;
    logic [CNT_W-1:0]  r_vcnt, w_vcnt_next;
    logic [CNT_W-1:0]  r_num_act, w_num_act_next;
    logic [ADDR_W-1:0] r_wgt_base, w_wgt_base_next;
    logic [ADDR_W-1:0] r_act_base, w_act_base_next;

    logic              r_busy, w_busy_next;
    logic              r_done, w_done_next;
    logic              r_mode, w_mode_next;
    logic              r_wgt_rd_en, w_wgt_rd_en_next;
    logic [ADDR_W-1:0] r_wgt_rd_addr, w_wgt_rd_addr_next;
    logic              r_act_rd_en, w_act_rd_en_next;
    logic [ADDR_W-1:0] r_act_rd_addr, w_act_rd_addr_next;

    // Next-state, counters, config latch, and the output values for the coming cycle.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_vcnt_next     = r_vcnt;
        w_num_act_next  = r_num_act;
        w_wgt_base_next = r_wgt_base;
        w_act_base_next = r_act_base;

        case (r_state)
            SA_IDLE: begin
                if (i_start) begin
                    w_num_act_next  = i_num_act;
                    w_wgt_base_next = i_wgt_base;
                    w_act_base_next = i_act_base;
                    w_cnt_next      = '0;
                    w_vcnt_next     = '0;
                    if (!i_skip_wload) begin
                        w_state_next = SA_LOAD_W;
                    end else if (i_num_act == '0) begin
                        w_state_next = SA_DONE;
                    end else begin
                        w_state_next = SA_COMPUTE;
                    end
                end
            end
            SA_LOAD_W: begin
                if (r_cnt == LOAD_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = (r_num_act == '0) ? SA_DONE : SA_COMPUTE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            SA_COMPUTE: begin
                // Counter stops at M-1, so M = 2^CNT_W-1 never wraps.
                if (r_vcnt == r_num_act - CNT_W'(1)) begin
                    w_cnt_next   = '0;
                    w_state_next = SA_DRAIN;
                end else begin
                    w_vcnt_next = r_vcnt + 1'b1;
                end
            end
            SA_DRAIN: begin
                if (r_cnt == DRAIN_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = SA_DONE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            SA_DONE: begin
                w_state_next = SA_IDLE;
            end
            default: begin
                w_state_next = SA_IDLE;
            end
        endcase

        // Outputs are registered, so derive them from the state being entered.
        w_busy_next        = (w_state_next != SA_IDLE);
        w_done_next        = (w_state_next == SA_DONE);
        w_mode_next        = (w_state_next == SA_COMPUTE) || (w_state_next == SA_DRAIN);
        w_wgt_rd_en_next   = (w_state_next == SA_LOAD_W) && (w_cnt_next < ROWS_C);
        w_wgt_rd_addr_next = w_wgt_base_next + WGT_TOP - ADDR_W'(w_cnt_next);
        w_act_rd_en_next   = (w_state_next == SA_COMPUTE);
        w_act_rd_addr_next = w_act_base_next + ADDR_W'(w_vcnt_next);
    end

    // State, counters, latched config and registered outputs; reset aborts any job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= SA_IDLE;
            r_cnt         <= '0;
            r_vcnt        <= '0;
            r_num_act     <= '0;
            r_wgt_base    <= '0;
            r_act_base    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mode        <= 1'b0;
            r_wgt_rd_en   <= 1'b0;
            r_wgt_rd_addr <= '0;
            r_act_rd_en   <= 1'b0;
            r_act_rd_addr <= '0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_vcnt        <= w_vcnt_next;
            r_num_act     <= w_num_act_next;
            r_wgt_base    <= w_wgt_base_next;
            r_act_base    <= w_act_base_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;
            r_mode        <= w_mode_next;
            r_wgt_rd_en   <= w_wgt_rd_en_next;
            r_wgt_rd_addr <= w_wgt_rd_addr_next;
            r_act_rd_en   <= w_act_rd_en_next;
            r_act_rd_addr <= w_act_rd_addr_next;
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_mode        = r_mode;
    assign o_wgt_rd_en   = r_wgt_rd_en;
    assign o_wgt_rd_addr = r_wgt_rd_addr;
    assign o_act_rd_en   = r_act_rd_en;
    assign o_act_rd_addr = r_act_rd_addr;

    sa_vld_pipe #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .RD_LAT (RD_LAT)
    ) u_vld_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_strobe  (r_act_rd_en),
        .o_col_vld (o_col_vld)
    );

endmodule

// File: tb/tb_sa_ctrl.sv
// Self-checking bench for sa_ctrl: job table with per-cycle expected trace via a scoreboard queue.
module tb_sa_ctrl;

    localparam int ROWS      = 4;
    localparam int COLS      = 4;
    localparam int RD_LAT    = 1;
    localparam int CNT_W     = 8;
    localparam int ADDR_W    = 10;
    localparam int LOAD_LEN  = ROWS + RD_LAT;
    localparam int DRAIN_LEN = RD_LAT + ROWS + COLS - 1;

    logic              clk;
    logic              rst_n;
    logic              i_start;
    logic              i_skip_wload;
    logic [CNT_W-1:0]  i_num_act;
    logic [ADDR_W-1:0] i_wgt_base;
    logic [ADDR_W-1:0] i_act_base;
    logic              o_busy;
    logic              o_done;
    logic              o_mode;
    logic              o_wgt_rd_en;
    logic [ADDR_W-1:0] o_wgt_rd_addr;
    logic              o_act_rd_en;
    logic [ADDR_W-1:0] o_act_rd_addr;
    logic [COLS-1:0]   o_col_vld;

    sa_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .RD_LAT(RD_LAT), .CNT_W(CNT_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_skip_wload  (i_skip_wload),
        .i_num_act     (i_num_act),
        .i_wgt_base    (i_wgt_base),
        .i_act_base    (i_act_base),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_mode        (o_mode),
        .o_wgt_rd_en   (o_wgt_rd_en),
        .o_wgt_rd_addr (o_wgt_rd_addr),
        .o_act_rd_en   (o_act_rd_en),
        .o_act_rd_addr (o_act_rd_addr),
        .o_col_vld     (o_col_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic              mode;
        logic              wre;
        logic [ADDR_W-1:0] wra;
        logic              are;
        logic [ADDR_W-1:0] ara;
        logic [COLS-1:0]   vld;
    } out_t;

    typedef struct {
        bit                skip;
        int                m;
        logic [ADDR_W-1:0] wb;
        logic [ADDR_W-1:0] ab;
        logic [31:0]       pulses;   // extra i_start pulses, bit t = during cycle t
        bit                chain;    // start in the IDLE cycle right after the previous job
        int                exp_done; // cycle of the o_done pulse
        int                exp_wrd;  // weight reads
        int                exp_ard;  // activation reads
        int                exp_vld;  // total o_col_vld bits seen
    } job_t;

    localparam int NJOBS = 8;
    job_t jobs [NJOBS];
    out_t exp_q [$];

    int checks = 0;
    int errors = 0;

    // Expected outputs in cycle t of a job, from the job timeline.
    function automatic out_t exp_at(input int t, input bit skip, input int m,
                                    input logic [ADDR_W-1:0] wb, input logic [ADDR_W-1:0] ab);
        out_t e;
        int lw, cs, ce, done_c, r;
        e      = '0;
        lw     = skip ? 0 : LOAD_LEN;
        cs     = lw + 1;
        ce     = lw + m;
        done_c = (m == 0) ? lw + 1 : lw + m + DRAIN_LEN + 1;
        e.busy = (t >= 1) && (t <= done_c);
        e.done = (t == done_c);
        e.wre  = !skip && (t >= 1) && (t <= ROWS);
        e.wra  = wb + ADDR_W'(ROWS - t);
        e.are  = (m > 0) && (t >= cs) && (t <= ce);
        e.ara  = ab + ADDR_W'(t - cs);
        e.mode = (m > 0) && (t >= cs) && (t < done_c);
        for (int c = 0; c < COLS; c++) begin
            r = t - (RD_LAT + ROWS + c);
            e.vld[c] = (m > 0) && (r >= cs) && (r <= ce);
        end
        return e;
    endfunction

    function automatic out_t sample();
        out_t a;
        a.busy = o_busy;
        a.done = o_done;
        a.mode = o_mode;
        a.wre  = o_wgt_rd_en;
        a.wra  = o_wgt_rd_addr;
        a.are  = o_act_rd_en;
        a.ara  = o_act_rd_addr;
        a.vld  = o_col_vld;
        return a;
    endfunction

    // Pop the expected record for this cycle and compare; addresses only matter with their strobe.
    task automatic check_cycle(input int j, input int t);
        out_t e, a;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL job%0d cycle%0d: scoreboard empty", j, t);
        end else begin
            e = exp_q.pop_front();
            a = sample();
            if (a.busy !== e.busy || a.done !== e.done || a.mode !== e.mode ||
                a.wre !== e.wre || a.are !== e.are || a.vld !== e.vld ||
                (e.wre && a.wra !== e.wra) || (e.are && a.ara !== e.ara)) begin
                errors++;
                $display("FAIL job%0d cycle%0d trace: got busy%b done%b mode%b wre%b wra%h are%b ara%h vld%b, want busy%b done%b mode%b wre%b wra%h are%b ara%h vld%b",
                         j, t, a.busy, a.done, a.mode, a.wre, a.wra, a.are, a.ara, a.vld,
                         e.busy, e.done, e.mode, e.wre, e.wra, e.are, e.ara, e.vld);
            end
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic run_job(input int j);
        job_t jb;
        int wrd, ard, vldn, ndone, done_at, last;
        jb = jobs[j];
        wrd = 0; ard = 0; vldn = 0; ndone = 0; done_at = -1;
        last = jb.exp_done + 1;
        if (!jb.chain) repeat (2) @(negedge clk);
        // Cycle 0: request is sampled at the coming rising edge.
        i_skip_wload = jb.skip;
        i_num_act    = CNT_W'(jb.m);
        i_wgt_base   = jb.wb;
        i_act_base   = jb.ab;
        i_start      = 1'b1;
        exp_q.push_back(exp_at(1, jb.skip, jb.m, jb.wb, jb.ab));
        for (int t = 1; t <= last; t++) begin
            @(negedge clk);
            check_cycle(j, t);
            wrd += int'(o_wgt_rd_en);
            ard += int'(o_act_rd_en);
            vldn += $countones(o_col_vld);
            if (o_done) begin
                ndone++;
                if (done_at < 0) done_at = t;
            end
            if (t < last) exp_q.push_back(exp_at(t + 1, jb.skip, jb.m, jb.wb, jb.ab));
            i_start = (t < 32) ? jb.pulses[t] : 1'b0;
            // Scramble the other inputs; they must only matter when latched.
            i_num_act  = CNT_W'($urandom);
            i_wgt_base = ADDR_W'($urandom);
            i_act_base = ADDR_W'($urandom);
        end
        i_start = 1'b0;
        check_int($sformatf("job%0d done_cycle", j), (ndone == 1) ? done_at : -ndone, jb.exp_done);
        check_int($sformatf("job%0d wgt_reads", j), wrd, jb.exp_wrd);
        check_int($sformatf("job%0d act_reads", j), ard, jb.exp_ard);
        check_int($sformatf("job%0d vld_bits", j), vldn, jb.exp_vld);
        $display("job%0d skip=%0d M=%0d wb=%h ab=%h: done@%0d wrd=%0d ard=%0d vld=%0d",
                 j, jb.skip, jb.m, jb.wb, jb.ab, done_at, wrd, ard, vldn);
    endtask

    initial begin
        int vld_seen, done_seen;
        //               skip  M    wb      ab      pulses                         chain done wrd ard vld
        jobs[0] = '{1'b0, 3,   10'h010, 10'h020, 32'h0,                          1'b0, 17,  4,  3,  12};
        jobs[1] = '{1'b1, 2,   10'h010, 10'h3FF, 32'h0,                          1'b0, 11,  0,  2,  8};
        jobs[2] = '{1'b0, 0,   10'h055, 10'h066, 32'h0,                          1'b0, 6,   4,  0,  0};
        jobs[3] = '{1'b1, 0,   10'h055, 10'h066, 32'h0,                          1'b0, 1,   0,  0,  0};
        jobs[4] = '{1'b0, 3,   10'h010, 10'h020, (32'h1 << 3) | (32'h1 << 9) | (32'h1 << 17), 1'b0, 17, 4, 3, 12};
        jobs[5] = '{1'b1, 1,   10'h3FE, 10'h100, 32'h0,                          1'b1, 10,  0,  1,  4};
        jobs[6] = '{1'b1, 255, 10'h000, 10'h200, 32'h0,                          1'b0, 264, 0,  255, 1020};
        jobs[7] = '{1'b0, 1,   10'h3FE, 10'h3FF, 32'h0,                          1'b0, 15,  4,  1,  4};

        // Reset held with a pending request: everything stays quiet.
        rst_n = 1'b0; i_start = 1'b1; i_skip_wload = 1'b0;
        i_num_act = 8'd3; i_wgt_base = 10'h010; i_act_base = 10'h020;
        repeat (3) @(negedge clk);
        check_int("reset_outputs", int'(sample()), 0);
        i_start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_int("idle_after_reset", int'({o_busy, o_done, o_mode, o_wgt_rd_en, o_act_rd_en, o_col_vld}), 0);
        $display("reset: outputs=%h", sample());

        for (int j = 0; j < NJOBS; j++) run_job(j);

        // Abort in cycle 7 of a full job: asynchronous clear, no done, no stray valids.
        repeat (2) @(negedge clk);
        i_skip_wload = 1'b0; i_num_act = 8'd3; i_wgt_base = 10'h010; i_act_base = 10'h020;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (6) @(negedge clk);
        check_int("abort_in_compute", int'(o_act_rd_en), 1);
        #2 rst_n = 1'b0;
        #1 check_int("abort_async_clear", int'(sample()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        vld_seen = 0; done_seen = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            vld_seen += $countones(o_col_vld);
            done_seen += int'(o_done) + int'(o_busy);
        end
        check_int("abort_no_vld", vld_seen, 0);
        check_int("abort_no_done_busy", done_seen, 0);
        $display("abort: vld_bits=%0d done_or_busy=%0d", vld_seen, done_seen);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
